// File: rtl/chiplet_types_pkg.sv
// Shared types and width helpers for the chiplet switch.
// Holds the switch-allocator state type and index widths.
package chiplet_types_pkg;

   typedef enum logic {SA_IDLE, SA_LOCKED} sa_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int SA_NUM_OUTPORTS = 4;
   localparam int SA_NUM_BUFFERS  = 4;
   localparam int SA_NUM_VCS      = 2;

   localparam int OUTPORT_W = idx_w(SA_NUM_OUTPORTS);
   localparam int VC_W      = idx_w(SA_NUM_VCS);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or
// after ptr, wrapping modulo N.
module rr_arbiter
   import chiplet_types_pkg::*;
#(
   parameter int N = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx
);

   always_comb begin
      int idx;
      idx       = 0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      // Scan farthest offset first so the nearest request wins last.
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator with round-robin
// arbitration and per-VC credit gating.
module switch_allocator
   import chiplet_types_pkg::*;
#(
   parameter int NUM_OUTPORTS = SA_NUM_OUTPORTS,
   parameter int NUM_BUFFERS  = SA_NUM_BUFFERS,
   parameter int NUM_VCS      = SA_NUM_VCS,
   localparam int OPW = idx_w(NUM_OUTPORTS),
   localparam int BW  = idx_w(NUM_BUFFERS),
   localparam int VW  = idx_w(NUM_VCS)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_BUFFERS-1:0]                 req_valid,
   input  logic [NUM_BUFFERS-1:0][OPW-1:0]        req_outport,
   input  logic [NUM_BUFFERS-1:0][VW-1:0]         req_vc,
   input  logic [NUM_BUFFERS-1:0]                 req_tail,
   input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]   credit_available,
   output logic [NUM_BUFFERS-1:0]                 grant,
   output logic [NUM_OUTPORTS-1:0]                out_valid,
   output logic [NUM_OUTPORTS-1:0][BW-1:0]        out_sel,
   output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]   credit_consume
);

   sa_state_t      state_q   [NUM_OUTPORTS];
   sa_state_t      state_d   [NUM_OUTPORTS];
   logic [BW-1:0]  owner_q   [NUM_OUTPORTS];
   logic [BW-1:0]  owner_d   [NUM_OUTPORTS];
   logic [VW-1:0]  lock_vc_q [NUM_OUTPORTS];
   logic [VW-1:0]  lock_vc_d [NUM_OUTPORTS];
   logic [BW-1:0]  rr_ptr_q  [NUM_OUTPORTS];
   logic [BW-1:0]  rr_ptr_d  [NUM_OUTPORTS];
   logic [BW-1:0]  win_idx   [NUM_OUTPORTS];

   logic [NUM_BUFFERS-1:0]                  owned;
   logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] elig;
   logic [NUM_OUTPORTS-1:0]                 win_valid;
   logic [NUM_OUTPORTS-1:0]                 fire;

   // A buffer already holding a locked port may not contend elsewhere.
   always_comb begin
      owned = '0;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         if (state_q[o] == SA_LOCKED) owned[owner_q[o]] = 1'b1;
      end
   end

   always_comb begin
      elig = '0;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         for (int b = 0; b < NUM_BUFFERS; b++) begin
            if (req_valid[b] && !owned[b] &&
                req_outport[b] == OPW'(o) &&
                int'(req_vc[b]) < NUM_VCS) begin
               elig[o][b] = credit_available[o][req_vc[b]];
            end
         end
      end
   end

   for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_arb
      rr_arbiter #(.N(NUM_BUFFERS)) u_arb (
         .req       (elig[o]),
         .ptr       (rr_ptr_q[o]),
         .gnt_valid (win_valid[o]),
         .gnt_idx   (win_idx[o])
      );
   end

   always_comb begin
      fire = '0;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         fire[o] = (state_q[o] == SA_LOCKED) &&
                   req_valid[owner_q[o]] &&
                   credit_available[o][lock_vc_q[o]];
      end
   end

   always_comb begin
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         state_d[o]   = state_q[o];
         owner_d[o]   = owner_q[o];
         lock_vc_d[o] = lock_vc_q[o];
         rr_ptr_d[o]  = rr_ptr_q[o];
         unique case (state_q[o])
            SA_IDLE: begin
               if (win_valid[o]) begin
                  state_d[o]   = SA_LOCKED;
                  owner_d[o]   = win_idx[o];
                  lock_vc_d[o] = req_vc[win_idx[o]];
               end
            end
            SA_LOCKED: begin
               if (fire[o] && req_tail[owner_q[o]]) begin
                  state_d[o]  = SA_IDLE;
                  rr_ptr_d[o] = (owner_q[o] == BW'(NUM_BUFFERS - 1))
                              ? '0 : owner_q[o] + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      grant          = '0;
      out_valid      = '0;
      out_sel        = '0;
      credit_consume = '0;
      if (!rst) begin
         for (int o = 0; o < NUM_OUTPORTS; o++) begin
            if (state_q[o] == SA_LOCKED) out_sel[o] = owner_q[o];
            if (fire[o]) begin
               grant[owner_q[o]]                 = 1'b1;
               out_valid[o]                      = 1'b1;
               credit_consume[o][lock_vc_q[o]]   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         if (rst) begin
            state_q[o]   <= SA_IDLE;
            owner_q[o]   <= '0;
            lock_vc_q[o] <= '0;
            rr_ptr_q[o]  <= '0;
         end else begin
            state_q[o]   <= state_d[o];
            owner_q[o]   <= owner_d[o];
            lock_vc_q[o] <= lock_vc_d[o];
            rr_ptr_q[o]  <= rr_ptr_d[o];
         end
      end
   end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-output-port packet arbiter for the chiplet switch: decides which input buffer drives each output port and when each flit may advance.
- Sits between the input buffers and the crossbar/out-port registers of the switch, and consumes per-output per-VC credit status.
- Grants are packet-granular (wormhole): an output port, once allocated, stays locked to one input and one VC until that packet's tail flit is granted.
- Arbitration among contenders is round-robin per output port.

Parameters:
NUM_OUTPORTS, 4, number of switch output ports
NUM_BUFFERS, 4, number of input buffers (requesters)
NUM_VCS, 2, virtual channels per link

Ports:
clk  input  1  switch clock
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_BUFFERS  input buffer b presents a flit at its head
req_outport  input  NUM_BUFFERS x $clog2(NUM_OUTPORTS)  destination output port of the head flit (from route compute)
req_vc  input  NUM_BUFFERS x $clog2(NUM_VCS)  downstream VC of the head flit
req_tail  input  NUM_BUFFERS  head flit is the packet's tail (single-flit packets assert this on the head)
credit_available  input  NUM_OUTPORTS x NUM_VCS  downstream VC on that output port has at least one credit
grant  output  NUM_BUFFERS  flit at buffer b is dequeued and forwarded this cycle
out_valid  output  NUM_OUTPORTS  crossbar drives a valid flit onto the output port this cycle
out_sel  output  NUM_OUTPORTS x $clog2(NUM_BUFFERS)  crossbar select: which input feeds the output port
credit_consume  output  NUM_OUTPORTS x NUM_VCS  one-cycle pulse, decrement that credit counter

Behaviour:
- Each output port o runs an independent FSM with state type sa_state_t: SA_IDLE and SA_LOCKED.
- Registered per-port state: owner[o], lock_vc[o], rr_ptr[o].
- Eligibility (SA_IDLE): input b is eligible for o when all of the following hold:
  - req_valid[b], and req_outport[b] == o;
  - credit_available[o][req_vc[b]];
  - b is not currently the owner of any locked port.
- SA_IDLE, at least one eligible input:
  - Winner is the first eligible input at or after rr_ptr[o], wrapping modulo NUM_BUFFERS.
  - Next cycle: SA_LOCKED, owner = winner, lock_vc = req_vc[winner].
  - No grant is issued in the allocation cycle.
  - Head-flit latency is therefore exactly 1 cycle from presentation to the earliest grant.
- SA_IDLE, no eligible input: stay in SA_IDLE; all outputs for o stay 0.
- SA_LOCKED, each cycle:
  - Fire condition: fire = req_valid[owner] && credit_available[o][lock_vc].
  - When fire is high, the following are combinational, in the same cycle:
    - grant[owner] = 1;
    - out_valid[o] = 1;
    - credit_consume[o][lock_vc] = 1.
  - out_sel[o] = owner whenever state is SA_LOCKED, regardless of fire.
  - fire && req_tail[owner]: next state SA_IDLE, rr_ptr[o] = (owner+1) mod NUM_BUFFERS.
  - Otherwise stay SA_LOCKED.
  - Missing credit or req_valid low (bubble) stalls the port; the lock is held and nothing is forwarded.
- Back-to-back packets: the port returns to SA_IDLE for one cycle after each tail, so there is a minimum 1 idle cycle between packets on a port.
- rr_ptr[o] updates only on tail completion, never on allocation alone.
- Multiple output ports may allocate or fire in the same cycle. grant is the OR across ports; at most one port ever selects a given input.
- out_sel[o] = 0 when out_valid[o] is 0 and state is SA_IDLE.
- Reset (rst high at a clock edge, including mid-packet):
  - All ports to SA_IDLE; owner, lock_vc and rr_ptr cleared to 0.
  - grant, out_valid, credit_consume and out_sel read 0 from the cycle after reset, and combinationally 0 while rst is high.
  - Partially forwarded packets are abandoned; buffer flush is the input buffers' responsibility.
- Width rules:
  - rr_ptr increment wraps explicitly for non-power-of-two NUM_BUFFERS.
  - req_outport values >= NUM_OUTPORTS are never eligible.

Decomposition:
- chiplet_types_pkg gains:
  - typedef enum logic sa_state_t {SA_IDLE, SA_LOCKED};
  - localparams for the out-port and VC index widths.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req [N], ptr [$clog2(N)].
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational; instantiated once per output port.
- switch_allocator holds all sequential state.

Test Plan:
- Single-flit packet: buffer 2 requests port 1, vc 0, tail=1, credit high at t0 -> SA_LOCKED at t1; grant[2], out_valid[1], out_sel[1]=2, credit_consume[1][0] all high at t1; SA_IDLE at t2; rr_ptr[1]=3.
- Contention: buffers 0 and 3 both request port 0 with 3-flit packets, rr_ptr=0 -> buffer 0 grants at t1–t3, idle at t4, buffer 3 allocates at t4 and grants at t5–t7.
- Credit stall: locked owner 1 on port 2 vc 1; credit_available[2][1] drops for 2 cycles mid-packet -> no grant/out_valid/consume during those cycles, lock held, resumes when credit returns.
- Ineligible at allocation: buffer 1 requests port 3 with credit_available[3][req_vc]=0 -> stays SA_IDLE; allocation occurs the cycle after credit rises.
- Parallel ports: buffer 0 -> port 1 and buffer 2 -> port 3 requested at once -> both locked at t1, both granted at t1, and grant=4'b0101.
- Reset mid-packet: rst asserted while port 0 is locked to buffer 3 after flit 2 of 4 -> next cycle all outputs 0, all ports SA_IDLE, rr_ptr=0; a new request allocates normally afterwards.
